alarm_cpu_debug_cmd_queue: RTL and testbench
============================================

// Module: alarm_cpu_debug_cmd_queue
// PURPOSE
// - Sysclk-side successor of the debug-slave command path: brings JTAG update-DR/update-IR
//   events into clk, queues {ir, sr} commands in a FIFO, pops under ready/valid.
// - Pops produce a held jdo word and one-cycle per-IR take_action/take_no_action strobes.
// - Generalised in IR width, DR width, sync depth and queue depth; adds overflow detect.
// - Sits between the virtual-JTAG TCK shift logic and the CPU OCI/break/trace controllers.
// PARAMETERS
// - IR_W         2   instruction register width; 2**IR_W command channels
// - DATA_W       38  DR snapshot width (sr, jdo)
// - ACT_BIT      34  data bit selecting action (1) vs no-action (0); must be < DATA_W
// - SYNC_STAGES  2   synchroniser flops for vs_udr/vs_uir; legal range 2..4
// - FIFO_DEPTH   4   command entries; power of 2, >= 2
// PORTS
// - clk             in   1              system clock; only clock
// - reset_n         in   1              synchronous, active-low reset
// - vs_udr          in   1              update-DR level from TCK domain; asynchronous
// - vs_uir          in   1              update-IR level from TCK domain; asynchronous
// - ir_in           in   IR_W           JTAG IR; stable while vs_uir/vs_udr high
// - sr              in   DATA_W         DR snapshot; stable while vs_udr high
// - cmd_ready       in   1              consumer accepts head entry
// - clr_overflow    in   1              clears sticky overflow
// - cmd_valid       out  1              FIFO non-empty
// - cmd_ir          out  IR_W           head entry IR
// - cmd_data        out  DATA_W         head entry data
// - jdo             out  DATA_W         data of last popped entry, held
// - take_action     out  2**IR_W        one-hot strobe: popped ir==k and data[ACT_BIT]=1
// - take_no_action  out  2**IR_W        one-hot strobe: popped ir==k and data[ACT_BIT]=0
// - ir_latched      out  IR_W           ir_in captured on last update-IR event
// - fifo_level      out  $clog2(FIFO_DEPTH)+1  occupied entries
// - overflow        out  1              sticky: an update-DR event was dropped
// BEHAVIOUR
// - Reset (reset_n==0 at clk edge): all outputs 0; synchronisers, edge regs and FIFO pointers cleared.
// - Arming: event detection is suppressed for SYNC_STAGES+1 cycles after reset release,
//   so levels held high across reset generate no event.
// - Synchronisation: each level passes SYNC_STAGES flops. Event = rising edge of the
//   synchronised level (sync-out high, previous sample low); one event per high pulse.
// - Update-IR event: ir_latched <= ir_in on the event cycle. No FIFO push.
// - Update-DR event: push {ir_in, sr}. Empty FIFO: cmd_valid rises SYNC_STAGES+2 edges after
//   the first edge sampling vs_udr high.
// - Pop = cmd_valid & cmd_ready. On the pop edge: jdo <= cmd_data; take_action[cmd_ir] or
//   take_no_action[cmd_ir] high for exactly the next cycle; all other strobe bits 0.
//   With no pop, all strobes are 0.
// - Full (fifo_level==FIFO_DEPTH) with no same-cycle pop: event dropped, overflow <= 1,
//   FIFO unchanged. Full with same-cycle pop: push accepted, level unchanged.
// - Simultaneous push and pop on a non-full FIFO: level unchanged, order preserved.
// - clr_overflow coincident with a drop: overflow stays 1 (set wins).
// - Pointers are IR_W-independent $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
//   Full/empty come from fifo_level, not pointer compare.
// - UDR and UIR events in the same cycle: push uses the pre-update ir_latched? No. Push uses
//   ir_in directly; ir_latched also updates. Both take effect.
// - Reset mid-operation: queued entries discarded, jdo cleared, in-flight sync edges lost.
// STRUCTURE
// - Package alarm_cpu_debug_pkg: IR encodings IR_OCIMEM=0, IR_TRACEMEM=1, IR_BREAK=2,
//   IR_TRACECTRL=3. Also ACT_BIT default and typedef for the {ir,data} entry.
// - Sub-module alarm_cpu_debug_sync_edge (SYNC_STAGES flops + edge detect + arm gating).
//   Instantiated twice (udr, uir).
// - FIFO storage: register array inline; no RAM inference required at these depths.
// TESTING
// - Reset release with vs_udr held 1: no cmd_valid, no overflow for 20 cycles.
// - One vs_udr pulse, ir_in=2, sr[34]=1, sr=38'h04_1234_5678, cmd_ready=1:
//   cmd_valid at SYNC_STAGES+2. Next cycle jdo=38'h04_1234_5678 and take_action=4'b0100
//   for 1 cycle.
// - 5 vs_udr pulses (DEPTH=4), cmd_ready=0: fifo_level=4, overflow=1. Then drain 4 entries
//   in order 1..4. Then clr_overflow -> overflow=0.
// - Full FIFO, cmd_ready=1 held, new event on the pop cycle: level stays 4, no overflow,
//   order kept.
// - vs_uir pulse with ir_in=3: ir_latched=3, fifo_level stays 0, no strobes.
// - reset_n=0 with 3 entries queued: next cycle cmd_valid=0, fifo_level=0, jdo=0,
//   strobes 0.

Source files
------------

// File: rtl/alarm_cpu_debug_pkg.sv
// Shared encodings and entry type for the sysclk-side debug command path.
package alarm_cpu_debug_pkg;

  localparam int DEF_IR_W    = 2;
  localparam int DEF_DATA_W  = 38;
  localparam int DEF_ACT_BIT = 34;

  localparam logic [DEF_IR_W-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [DEF_IR_W-1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [DEF_IR_W-1:0] IR_BREAK     = 2'd2;
  localparam logic [DEF_IR_W-1:0] IR_TRACECTRL = 2'd3;

  typedef struct packed {
    logic [DEF_IR_W-1:0]   ir;
    logic [DEF_DATA_W-1:0] data;
  } dbg_entry_t;

endpackage

// File: rtl/alarm_cpu_debug_sync_edge.sv
// Level synchroniser with registered rising-edge event, gated until the
// chain has flushed after reset so levels held across reset stay silent.
module alarm_cpu_debug_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic level_i,
  output logic event_o
);

  localparam logic [2:0] ARM_CNT = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   event_q;
  logic [2:0]             arm_cnt_q;
  logic                   armed;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign armed    = (arm_cnt_q == ARM_CNT);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      event_q   <= 1'b0;
      arm_cnt_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], level_i};
      prev_q  <= sync_out;
      event_q <= sync_out & ~prev_q & armed;
      if (!armed) arm_cnt_q <= arm_cnt_q + 3'd1;
    end
  end

  assign event_o = event_q;

endmodule

// File: rtl/alarm_cpu_debug_cmd_queue.sv
// Brings JTAG update-IR/update-DR into clk, queues {ir, sr} commands and
// turns each pop into a held jdo word plus a one-cycle per-IR strobe.
module alarm_cpu_debug_cmd_queue
  import alarm_cpu_debug_pkg::*;
#(
  parameter int IR_W        = DEF_IR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ACT_BIT     = DEF_ACT_BIT,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          vs_udr,
  input  logic                          vs_uir,
  input  logic [IR_W-1:0]               ir_in,
  input  logic [DATA_W-1:0]             sr,
  input  logic                          cmd_ready,
  input  logic                          clr_overflow,
  output logic                          cmd_valid,
  output logic [IR_W-1:0]               cmd_ir,
  output logic [DATA_W-1:0]             cmd_data,
  output logic [DATA_W-1:0]             jdo,
  output logic [2**IR_W-1:0]            take_action,
  output logic [2**IR_W-1:0]            take_no_action,
  output logic [IR_W-1:0]               ir_latched,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int N_CH  = 2**IR_W;

  typedef struct packed {
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic udr_evt, uir_evt;

  alarm_cpu_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_udr (
    .clk     (clk),
    .reset_n (reset_n),
    .level_i (vs_udr),
    .event_o (udr_evt)
  );

  alarm_cpu_debug_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_uir (
    .clk     (clk),
    .reset_n (reset_n),
    .level_i (vs_uir),
    .event_o (uir_evt)
  );

  entry_t            mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] jdo_q, jdo_d;
  logic [N_CH-1:0]   act_q, act_d;
  logic [N_CH-1:0]   nact_q, nact_d;
  logic [IR_W-1:0]   ir_latched_q, ir_latched_d;
  logic              overflow_q, overflow_d;

  entry_t head;
  logic   full, pop, push_ok, drop;

  assign head    = mem_q[rd_ptr_q];
  assign full    = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop     = (level_q != '0) & cmd_ready;
  // A pop on the same edge frees the slot the full-queue push lands in.
  assign push_ok = udr_evt & (~full | pop);
  assign drop    = udr_evt & full & ~pop;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    jdo_d        = jdo_q;
    act_d        = '0;
    nact_d       = '0;
    ir_latched_d = ir_latched_q;
    overflow_d   = overflow_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      jdo_d    = head.data;
      if (head.data[ACT_BIT]) act_d[head.ir]  = 1'b1;
      else                    nact_d[head.ir] = 1'b1;
    end

    case ({push_ok, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (uir_evt) ir_latched_d = ir_in;

    if (drop)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      jdo_q        <= '0;
      act_q        <= '0;
      nact_q       <= '0;
      ir_latched_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      jdo_q        <= jdo_d;
      act_q        <= act_d;
      nact_q       <= nact_d;
      ir_latched_q <= ir_latched_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= {ir_in, sr};
    end
  end

  assign cmd_valid      = (level_q != '0);
  assign cmd_ir         = head.ir;
  assign cmd_data       = head.data;
  assign jdo            = jdo_q;
  assign take_action    = act_q;
  assign take_no_action = nact_q;
  assign ir_latched     = ir_latched_q;
  assign fifo_level     = level_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_alarm_cpu_debug_cmd_queue.sv
// Scoreboard bench for the debug command queue: expected entries are queued
// as JTAG pulses are driven and checked as the queue pops them.
module tb_alarm_cpu_debug_cmd_queue;
  import alarm_cpu_debug_pkg::*;

  localparam int IR_W = 2;
  localparam int DW   = 38;
  localparam int ACT  = 34;
  localparam int NCH  = 4;

  logic          clk = 1'b0;
  logic          reset_n, vs_udr, vs_uir, cmd_ready, clr_overflow;
  logic [IR_W-1:0] ir_in;
  logic [DW-1:0] sr;
  logic          cmd_valid, overflow;
  logic [IR_W-1:0] cmd_ir, ir_latched;
  logic [DW-1:0] cmd_data, jdo;
  logic [NCH-1:0] take_action, take_no_action;
  logic [2:0]    fifo_level;

  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [DW-1:0]   data;
  } ent_t;

  ent_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [DW-1:0]  exp_jdo  = '0;
  logic [NCH-1:0] exp_act  = '0;
  logic [NCH-1:0] exp_nact = '0;

  always #5 clk = ~clk;

  alarm_cpu_debug_cmd_queue dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .ir_in          (ir_in),
    .sr             (sr),
    .cmd_ready      (cmd_ready),
    .clr_overflow   (clr_overflow),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .cmd_data       (cmd_data),
    .jdo            (jdo),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .ir_latched     (ir_latched),
    .fifo_level     (fifo_level),
    .overflow       (overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pop monitor: strobes/jdo one cycle after each pop, head order vs scoreboard.
  always @(negedge clk) begin
    check("jdo", 64'(jdo), 64'(exp_jdo));
    check("take_action", 64'(take_action), 64'(exp_act));
    check("take_no_action", 64'(take_no_action), 64'(exp_nact));
    exp_act  = '0;
    exp_nact = '0;
    if (!reset_n) begin
      exp_jdo = '0;
    end else if (cmd_valid && cmd_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_pop", 64'd1, 64'd0);
      end else begin
        ent_t e;
        e = sb.pop_front();
        check("head_ir", 64'(cmd_ir), 64'(e.ir));
        check("head_data", 64'(cmd_data), 64'(e.data));
        exp_jdo = e.data;
        if (e.data[ACT]) exp_act[e.ir]  = 1'b1;
        else             exp_nact[e.ir] = 1'b1;
      end
    end
  end

  function automatic logic [DW-1:0] mk_data(input int k);
    logic [DW-1:0] d;
    d = DW'(k * 38'h11);
    d[ACT] = k[0];
    return d;
  endfunction

  task automatic udr_pulse(input logic [IR_W-1:0] ir, input logic [DW-1:0] d);
    @(posedge clk); #1;
    ir_in = ir; sr = d; vs_udr = 1'b1;
    repeat (5) @(posedge clk);
    #1 vs_udr = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (cmd_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 64'(cmd_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    ent_t e;
    reset_n = 1'b0; vs_udr = 1'b1; vs_uir = 1'b0; ir_in = '0; sr = '0;
    cmd_ready = 1'b0; clr_overflow = 1'b0;

    repeat (3) @(posedge clk); #1;
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_irl", 64'(ir_latched), 64'd0);
    reset_n = 1'b1;

    // vs_udr held high across reset release must not produce an event
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("arm_valid", 64'(cmd_valid), 64'd0);
      check("arm_ovf", 64'(overflow), 64'd0);
    end
    vs_udr = 1'b0;
    repeat (5) @(posedge clk);

    // single command, latency and strobe
    cmd_ready = 1'b1;
    e = '{ir: IR_BREAK, data: 38'h04_1234_5678};
    sb.push_back(e);
    @(posedge clk); #1;
    ir_in = IR_BREAK; sr = 38'h04_1234_5678; vs_udr = 1'b1;
    lat = 0;
    while (!cmd_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), 64'd4);
    @(posedge clk); #1;
    check("single_jdo", 64'(jdo), 64'h04_1234_5678);
    check("single_act", 64'(take_action), 64'b0100);
    @(posedge clk); #1;
    check("single_act_clr", 64'(take_action), 64'd0);
    vs_udr = 1'b0;
    repeat (5) @(posedge clk);

    // fill past depth with no consumer, then drain in order
    cmd_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) begin
        e = '{ir: IR_W'(k), data: mk_data(k)};
        sb.push_back(e);
      end
      udr_pulse(IR_W'(k), mk_data(k));
    end
    #1;
    check("full_level", 64'(fifo_level), 64'd4);
    check("full_ovf", 64'(overflow), 64'd1);
    cmd_ready = 1'b1;
    wait_drain("drain1");
    check("drain1_level", 64'(fifo_level), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);
    cmd_ready = 1'b0;
    clr_overflow = 1'b1;
    @(posedge clk); #1;
    clr_overflow = 1'b0;
    check("ovf_clr", 64'(overflow), 64'd0);

    // full queue with a push landing on the first pop edge
    for (int k = 6; k <= 9; k++) begin
      e = '{ir: IR_W'(k), data: mk_data(k)};
      sb.push_back(e);
      udr_pulse(IR_W'(k), mk_data(k));
    end
    #1;
    check("full2_level", 64'(fifo_level), 64'd4);
    e = '{ir: IR_TRACEMEM, data: mk_data(10)};
    sb.push_back(e);
    @(posedge clk); #1;
    ir_in = IR_TRACEMEM; sr = mk_data(10); vs_udr = 1'b1;
    repeat (3) @(posedge clk);
    #1 cmd_ready = 1'b1;
    @(posedge clk); #1;
    check("pushpop_level", 64'(fifo_level), 64'd4);
    check("pushpop_ovf", 64'(overflow), 64'd0);
    @(posedge clk); #1;
    vs_udr = 1'b0;
    wait_drain("drain2");
    check("drain2_ovf", 64'(overflow), 64'd0);

    // update-IR only
    @(posedge clk); #1;
    ir_in = IR_TRACECTRL; vs_uir = 1'b1;
    repeat (5) @(posedge clk);
    #1 vs_uir = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("uir_latched", 64'(ir_latched), 64'd3);
    check("uir_level", 64'(fifo_level), 64'd0);

    // simultaneous update-IR and update-DR
    e = '{ir: IR_TRACEMEM, data: mk_data(11)};
    sb.push_back(e);
    @(posedge clk); #1;
    ir_in = IR_TRACEMEM; sr = mk_data(11); vs_uir = 1'b1; vs_udr = 1'b1;
    repeat (5) @(posedge clk);
    #1 begin vs_uir = 1'b0; vs_udr = 1'b0; end
    repeat (4) @(posedge clk); #1;
    check("both_latched", 64'(ir_latched), 64'd1);
    wait_drain("drain3");

    // reset with entries queued
    cmd_ready = 1'b0;
    for (int k = 12; k <= 14; k++) udr_pulse(IR_W'(k), mk_data(k));
    #1;
    check("pre_rst_level", 64'(fifo_level), 64'd3);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", 64'(cmd_valid), 64'd0);
    check("mid_rst_level", 64'(fifo_level), 64'd0);
    check("mid_rst_jdo", 64'(jdo), 64'd0);
    check("mid_rst_act", 64'({take_action, take_no_action}), 64'd0);
    reset_n = 1'b1;
    repeat (6) @(posedge clk);

    // queue works again after reset
    cmd_ready = 1'b1;
    e = '{ir: IR_OCIMEM, data: mk_data(15)};
    sb.push_back(e);
    udr_pulse(IR_OCIMEM, mk_data(15));
    wait_drain("drain4");
    repeat (2) @(posedge clk); #1;
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
